// File: rtl/sram_responder_if.sv
// sram_responder_if
//   Pixel-bus bundle between a single initiator and the SRAM responder.
//   Signal names follow the responder's point of view (_i into the
//   responder, _o out of it).
//   Ports of the bundle:
//     stb_i   request strobe, held by the initiator until ack_o
//     we_i    1 = write, 0 = read
//     sel_i   active-low byte-lane selects (bit0 low byte, bit1 high byte)
//     adr_i   word address
//     dat_i   write data
//     dat_o   read data, held until the next read completes
//     ack_o   one-cycle completion pulse
//     busy_o  access in progress (initiator's cyc_i)
//   Modports: slave for the responder, master for the initiator.
interface sram_responder_if #(
  parameter int DATW = 16,
  parameter int ADRW = 18
);
  logic            stb_i;
  logic            we_i;
  logic [1:0]      sel_i;
  logic [ADRW-1:0] adr_i;
  logic [DATW-1:0] dat_i;
  logic [DATW-1:0] dat_o;
  logic            ack_o;
  logic            busy_o;

  modport slave (
    input  stb_i, we_i, sel_i, adr_i, dat_i,
    output dat_o, ack_o, busy_o
  );

  modport master (
    output stb_i, we_i, sel_i, adr_i, dat_i,
    input  dat_o, ack_o, busy_o
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder
//   Accepts strobed read/write requests from the pixel bus and runs each
//   one as a timed access to an external asynchronous 16-bit SRAM, then
//   returns a one-cycle acknowledge. One request at a time, no queueing.
//   Sequence per request: IDLE -> SETUP (1) -> ACCESS (WAIT) -> ACK (1).
//   Ports:
//     clk_i, rst_i   clock (rising edge) and async active-high reset
//     bus            pixel-bus slave modport (stb/we/sel/adr/dat in,
//                    dat/ack/busy out)
//     sram_adr_o     SRAM address
//     sram_dq_o      SRAM write data, sram_dq_oe its tri-state enable
//     sram_dq_i      SRAM read data
//     sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
//                    active-low SRAM controls
//   Every output comes straight from a flop.
module sram_responder #(
  parameter int DATW = 16,
  parameter int ADRW = 18,
  parameter int WAIT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sram_responder_if.slave bus,
  output logic [ADRW-1:0] sram_adr_o,
  output logic [DATW-1:0] sram_dq_o,
  input  logic [DATW-1:0] sram_dq_i,
  output logic            sram_dq_oe,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic            sram_lb_n,
  output logic            sram_ub_n
);

  localparam int LANE = DATW / 2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ACK
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      sel_q, sel_d;
  logic [ADRW-1:0] adr_q, adr_d;
  logic [DATW-1:0] dat_q, dat_d;
  logic [DATW-1:0] rdat_q, rdat_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            dq_oe_q, dq_oe_d;
  logic            ce_n_q, ce_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            lb_n_q, lb_n_d;
  logic            ub_n_q, ub_n_d;

  // Lanes whose select is high (disabled) read back as zero.
  logic [DATW-1:0] rd_mask;
  assign rd_mask = {{LANE{~sel_q[1]}}, {LANE{~sel_q[0]}}};

  // SRAM control outputs are registered, so each one is set on the edge
  // that enters the state in which it must be active.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    lb_n_d  = lb_n_q;
    ub_n_d  = ub_n_q;

    case (state_q)
      IDLE: begin
        if (bus.stb_i) begin
          state_d = SETUP;
          we_d    = bus.we_i;
          sel_d   = bus.sel_i;
          adr_d   = bus.adr_i;
          dat_d   = bus.dat_i;
          busy_d  = 1'b1;
          // Both lanes disabled: full timing, but the chip is never selected.
          ce_n_d  = &bus.sel_i;
          lb_n_d  = bus.sel_i[0];
          ub_n_d  = bus.sel_i[1];
          oe_n_d  = bus.we_i | (&bus.sel_i);
          dq_oe_d = bus.we_i;
        end
      end

      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WAIT_LOAD;
        we_n_d  = ~we_q | (&sel_q);
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (!we_q) begin
            rdat_d = sram_dq_i & rd_mask;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ACK: begin
        // Strobe is deliberately ignored here; the next request can only
        // be taken from IDLE.
        state_d = IDLE;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
    end
  end

  // Latched request address/data drive the SRAM pins directly, which
  // keeps them stable from SETUP through the ACK hold cycle.
  assign sram_adr_o = adr_q;
  assign sram_dq_o  = dat_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;

  assign bus.dat_o  = rdat_q;
  assign bus.ack_o  = ack_q;
  assign bus.busy_o = busy_q;

endmodule

// File: doc/sram_responder.md
# sram_responder

Bus responder for the single-master pixel bus driven by the 2D copy engine and similar initiators. It accepts strobed read and write requests on the bus. It runs each request as a timed access to an external asynchronous 16-bit SRAM, then returns a one-cycle acknowledge. While an access is in flight it raises a busy flag, which initiators sample on their `cyc_i` input before strobing again.

## Interface
- `DATW`, 16, data width (SRAM word).
- `ADRW`, 18, word address width.
- `WAIT`, 2, SRAM access cycles (legal range 1..15).
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `stb_i`  in  1  request strobe; initiator holds it high until it sees `ack_o`.
- `we_i`  in  1  1 = write, 0 = read; sampled with `stb_i`.
- `sel_i`  in  2  byte-lane selects, active-low; bit0 = low byte, bit1 = high byte.
- `adr_i`  in  ADRW  word address.
- `dat_i`  in  DATW  write data.
- `dat_o`  out  DATW  read data; valid in the `ack_o` cycle of a read, held until the next read completes.
- `ack_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  access in progress; connects to the initiator's `cyc_i`.
- `sram_adr_o`  out  ADRW  SRAM address.
- `sram_dq_o`  out  DATW  SRAM write data.
- `sram_dq_i`  in  DATW  SRAM read data.
- `sram_dq_oe`  out  1  tri-state enable for `sram_dq_o` (top level builds the pad).
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n`  out  1 each  SRAM controls, active-low.

## Operation
- States: IDLE, SETUP, ACCESS, ACK.
- **IDLE**
  - `stb_i`=1: latch `we_i`, `sel_i`, `adr_i`, `dat_i` into request registers; set `busy_o`=1; go to SETUP.
  - Otherwise stay in IDLE with all SRAM controls inactive.
- **SETUP** (1 cycle)
  - `sram_adr_o` = latched address.
  - `sram_ce_n`=0 unless both lanes are disabled; `sram_lb_n`=`sel[0]`, `sram_ub_n`=`sel[1]`.
  - Read: `sram_oe_n`=0.
  - Write: `sram_dq_oe`=1, `sram_dq_o` = latched data.
  - Load wait counter with `WAIT`-1; go to ACCESS.
- **ACCESS** (`WAIT` cycles)
  - Write: `sram_we_n`=0.
  - Counter decrements each cycle. When it is 0, go to ACK.
  - On that transition edge, a read captures `sram_dq_i` into `dat_o`. Bytes in disabled lanes are forced to 0.
- **ACK** (1 cycle)
  - `ack_o`=1; `sram_we_n`=1 and `sram_oe_n`=1.
  - Write keeps `sram_dq_oe`=1 for this cycle as data hold time.
  - `stb_i` is ignored in this state. Go to IDLE.
- **Leaving ACK**
  - `busy_o`, `sram_ce_n`, the lane enables and `sram_dq_oe` all return to inactive.
  - `ack_o` returns to 0.
- Requests are served strictly one at a time; there is no queueing.
- A strobe that arrives while `busy_o`=1 is not latched. The initiator must hold `stb_i` until it is acknowledged.
- Request registers are frozen from acceptance to ACK. Changes on the bus mid-access have no effect.
- `sel_i`=2'b11 runs the full state sequence with identical timing and `ack_o`, but generates no SRAM strobes. A read in this case returns 0.
- Reset is asynchronous and valid in any state. It returns the FSM to IDLE, clears the counter and request registers, and drives every output to its reset value. An access in flight is abandoned and never acked.

## Timing
- Reset values:
  - `ack_o`=0, `busy_o`=0, `dat_o`=0.
  - `sram_adr_o`=0, `sram_dq_o`=0, `sram_dq_oe`=0.
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` all =1.
- Let E0 be the edge that samples `stb_i`=1 in IDLE.
  - `busy_o` is high from after E0 until after edge E0+`WAIT`+2.
  - `ack_o` is high between E0+`WAIT`+1 and E0+`WAIT`+2.
- Latency from strobe sample to ack = `WAIT`+1 cycles. Occupancy = `WAIT`+2 cycles.
- Back-to-back throughput: one access per `WAIT`+3 cycles. The minimum is one IDLE cycle between accesses.
- The initiator clears `stb_i` on the edge where it sees `ack_o`. The responder returns to IDLE on the same edge, so the same request is never accepted twice.
- Write-cycle SRAM relationships:
  - Address and data are stable one cycle before `sram_we_n` falls.
  - `sram_we_n` is low for exactly `WAIT` cycles.
  - Data is held one cycle after `sram_we_n` rises.
- All outputs are registered; there are no combinational paths from bus inputs to outputs.

## Test plan
- Reset mid-write: `WAIT`=2, assert `rst_i` asynchronously during ACCESS. Required: all outputs at reset values immediately, no `ack_o`, FSM in IDLE, next request serviced normally.
- Single write: `WAIT`=2, `adr_i`=0x00155, `dat_i`=0xA5C3, `sel_i`=00. Required:
  - `sram_we_n` low exactly 2 cycles with `sram_adr_o`=0x00155 and `sram_dq_o`=0xA5C3.
  - `ack_o` at E0+3; `busy_o` high 4 cycles.
- Single read: SRAM model returns 0x1234 at 0x3FFFF, `sel_i`=00. Required: `dat_o`=0x1234 in the ack cycle, `sram_oe_n` low for SETUP+ACCESS, `sram_dq_oe` stays 0.
- Byte lanes:
  - Read with `sel_i`=10 from a word holding 0xBEEF. Required: `dat_o`=0x00EF and `sram_ub_n`=1.
  - Request with `sel_i`=11. Required: `ack_o` at E0+3, `sram_ce_n` never low.
- Back-to-back with copy-engine behaviour: a write is immediately followed by a read strobe gated on `busy_o`. Required: the read is accepted only after the write's ACK; `ack_o` pulses exactly twice.
- Strobe held across ack: `stb_i` held high one cycle past `ack_o`. Required: exactly one additional access starts, from IDLE, after the ACK cycle. A strobe low in the ack cycle starts nothing.
